bcd_sequencial: RTL and testbench
=================================

Name: bcd_sequencial

Overview:
- Multi-cycle binary-to-BCD converter using the double-dabble (shift-add-3) algorithm. It processes one input bit per clock.
- It is parametrised in input width and output digit count.
- It has a start/busy/done handshake and overflow detection.
- It sits between the processor's output path and the 7-segment display drivers. It is gated by the same controlesaida output-select code.

Parameters:
- WIDTH, 32, width of the binary input in bits (>=4).
- DIGITS, 10, number of BCD digits produced (>=1). Digit 0 is the units digit.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- inicio  input  1  start request. Sampled on the rising edge.
- controlesaida  input  2  output-select code. A conversion starts only when it equals 2'b01.
- binario  input  WIDTH  value to convert. Captured at start.
- ocupado  output  1  high while a conversion is in progress.
- pronto  output  1  one-cycle pulse when the result is valid.
- digitos  output  4*DIGITS  packed BCD result. Digit i is at bits [4i+3:4i].
- overflow  output  1  value does not fit in DIGITS digits. Valid with pronto.
- negativo  output  1  sign flag. See Optional Feature.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to OCIOSO.
  - ocupado=0, pronto=0, overflow=0, negativo=0, digitos=0.
  - Internal shift register and bit counter are cleared.
  - Reset takes priority over every other event, including mid-conversion. Any partial result is discarded.
- States: OCIOSO, DESLOCA, FIM.
- OCIOSO:
  - Start is accepted when inicio==1 and controlesaida==2'b01.
  - On acceptance: capture binario into the shift register, clear the working digits, clear the overflow flag, load the counter with WIDTH, and go to DESLOCA.
  - If inicio==1 with any other controlesaida value, stay in OCIOSO with no change.
- DESLOCA, one input bit per cycle:
  - For every working digit >=5, add 3 (mod 16).
  - Then shift the concatenation {digits, shift register} left by 1.
  - The MSB of the shift register enters bit 0 of digit 0.
  - Decrement the counter. Leave DESLOCA after exactly WIDTH cycles.
  - ocupado=1 throughout DESLOCA.
- Overflow: if any shift moves a 1 out of bit 3 of the top digit, set overflow. The flag is sticky for the rest of the conversion.
- FIM, one cycle:
  - pronto=1, ocupado=0. Working digits are copied to digitos; overflow is updated.
  - Return to OCIOSO.
  - A valid start in FIM is accepted in the same cycle, so back-to-back conversions are allowed.
- Latency: start sampled at edge k gives pronto high during the cycle after edge k+WIDTH+1. Throughput is one conversion per WIDTH+1 cycles.
- digitos, overflow and negativo hold their last result until the next FIM. They are not cleared by a new start.
- Ignored inputs:
  - inicio during DESLOCA is ignored (no queueing).
  - Changes to binario after capture are ignored.
  - controlesaida changes during DESLOCA do not abort the conversion.
- On overflow, digitos holds the low DIGITS digits of the decimal value, i.e. the value mod 10^DIGITS.
- Width rule: the default DIGITS=10 covers 2^32-1. Generic sizing is DIGITS >= ceil(WIDTH*log10(2)); smaller values are legal and exercise overflow.

Optional Feature:
- Macro: BCD_SINAL_EN.
- Defined:
  - binario is two's complement.
  - At start, if binario[WIDTH-1]==1, capture its negation (magnitude) and set an internal sign bit.
  - negativo is updated with the other outputs at FIM.
  - The most negative value -2^(WIDTH-1) converts correctly as magnitude 2^(WIDTH-1), because the magnitude is treated as unsigned WIDTH bits.
- Not defined: input is unsigned and negativo is a constant 0.

Test Plan:
- WIDTH=32, DIGITS=10, binario=255, inicio pulse with controlesaida=01 → ocupado for 32 cycles, then pronto one cycle; digitos=...0000_0010_0101_0101 (0000000255); overflow=0.
- binario=32'hFFFFFFFF → digitos=4294967295 digit-by-digit; overflow=0. Immediate second start during FIM with binario=0 → accepted; next pronto 33 cycles later; digitos=0.
- WIDTH=16, DIGITS=3, binario=1000 → overflow=1, digitos=000. binario=999 → overflow=0, digitos=999.
- inicio with controlesaida=10 → no ocupado, outputs unchanged. inicio re-pulsed mid-conversion → ignored; pronto exactly once, at the original latency.
- reset low at cycle 10 of a conversion → next edge ocupado=0, digitos=0, no pronto. A new start afterwards completes normally.
- With BCD_SINAL_EN, WIDTH=8, DIGITS=3:
  - binario=8'h85 (-123) → digitos=123, negativo=1.
  - binario=8'h80 → digitos=128, negativo=1.
  - Without the macro, 8'h85 → digitos=133, negativo=0.

Source files
------------

// File: rtl/bcd_sequencial_if.sv
// Handshake and data bundle between the output path and the BCD converter.
// Slave modport is the converter side; master is the requester side.
interface bcd_sequencial_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);
  logic                  inicio;
  logic [1:0]            controlesaida;
  logic [WIDTH-1:0]      binario;
  logic                  ocupado;
  logic                  pronto;
  logic [4*DIGITS-1:0]   digitos;
  logic                  overflow;
  logic                  negativo;

  modport master (
    output inicio, controlesaida, binario,
    input  ocupado, pronto, digitos, overflow, negativo
  );

  modport slave (
    input  inicio, controlesaida, binario,
    output ocupado, pronto, digitos, overflow, negativo
  );
endinterface

// File: rtl/bcd_sequencial.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Define BCD_SINAL_EN to treat binario as two's complement and report the sign.
module bcd_sequencial #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input logic             clock,
  input logic             reset,
  bcd_sequencial_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {OCIOSO, DESLOCA, FIM} state_t;

  state_t                r_state;
  logic [WIDTH-1:0]      r_shift;
  logic [4*DIGITS-1:0]   r_work;
  logic [CW-1:0]         r_cnt;
  logic                  r_ovf;
  logic                  r_ocupado;
  logic                  r_pronto;
  logic [4*DIGITS-1:0]   r_digitos;
  logic                  r_overflow;
`ifdef BCD_SINAL_EN
  logic                  r_sign;
  logic                  r_negativo;
`endif

  logic                  w_start;
  logic                  w_load;
  logic [WIDTH-1:0]      w_mag;
  logic                  w_neg;
  logic [4*DIGITS-1:0]   w_adj;

  always_comb begin
    w_start = bus.inicio && (bus.controlesaida == 2'b01);
    w_load  = w_start && (r_state == OCIOSO || r_state == FIM);
`ifdef BCD_SINAL_EN
    w_neg   = bus.binario[WIDTH-1];
    w_mag   = w_neg ? (~bus.binario + 1'b1) : bus.binario;
`else
    w_neg   = 1'b0;
    w_mag   = bus.binario;
`endif
    w_adj   = r_work;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_work[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
      end
    end
  end

  // A start seen in FIM overrides the return to OCIOSO, giving back-to-back conversions.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= OCIOSO;
      r_shift    <= '0;
      r_work     <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_ocupado  <= 1'b0;
      r_pronto   <= 1'b0;
      r_digitos  <= '0;
      r_overflow <= 1'b0;
`ifdef BCD_SINAL_EN
      r_sign     <= 1'b0;
      r_negativo <= 1'b0;
`endif
    end else begin
      r_pronto <= 1'b0;
      case (r_state)
        OCIOSO: ;
        DESLOCA: begin
          r_work  <= {w_adj[4*DIGITS-2:0], r_shift[WIDTH-1]};
          r_shift <= {r_shift[WIDTH-2:0], 1'b0};
          r_ovf   <= r_ovf | w_adj[4*DIGITS-1];
          r_cnt   <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state   <= FIM;
            r_ocupado <= 1'b0;
          end
        end
        FIM: begin
          r_pronto   <= 1'b1;
          r_digitos  <= r_work;
          r_overflow <= r_ovf;
`ifdef BCD_SINAL_EN
          r_negativo <= r_sign;
`endif
          r_state    <= OCIOSO;
        end
        default: r_state <= OCIOSO;
      endcase
      if (w_load) begin
        r_shift   <= w_mag;
        r_work    <= '0;
        r_ovf     <= 1'b0;
        r_cnt     <= CW'(WIDTH);
        r_state   <= DESLOCA;
        r_ocupado <= 1'b1;
`ifdef BCD_SINAL_EN
        r_sign    <= w_neg;
`endif
      end
    end
  end

  assign bus.ocupado  = r_ocupado;
  assign bus.pronto   = r_pronto;
  assign bus.digitos  = r_digitos;
  assign bus.overflow = r_overflow;
`ifdef BCD_SINAL_EN
  assign bus.negativo = r_negativo;
`else
  assign bus.negativo = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_sequencial.sv
// Scoreboard bench for bcd_sequencial: three instances (32/10, 16/3, 8/3).
// Expected results are computed by decimal division, independent of double dabble.
module tb_bcd_sequencial;

  typedef struct {
    logic [63:0] dig;
    logic        ovf;
    logic        neg;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   nChecks = 0;
  int   nMiscompares = 0;
  exp_t q32[$];
  exp_t q16[$];
  exp_t q8[$];

  bcd_sequencial_if #(.WIDTH(32), .DIGITS(10)) bus32();
  bcd_sequencial_if #(.WIDTH(16), .DIGITS(3))  bus16();
  bcd_sequencial_if #(.WIDTH(8),  .DIGITS(3))  bus8();

  bcd_sequencial #(.WIDTH(32), .DIGITS(10)) u32 (.clock(clock), .reset(reset), .bus(bus32));
  bcd_sequencial #(.WIDTH(16), .DIGITS(3))  u16 (.clock(clock), .reset(reset), .bus(bus16));
  bcd_sequencial #(.WIDTH(8),  .DIGITS(3))  u8  (.clock(clock), .reset(reset), .bus(bus8));

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mkExp(input logic [31:0] v, input int w, input int d, input int pcyc);
    exp_t e;
    longint unsigned mag, lim, t;
    mag = longint'(v) & ((64'd1 << w) - 64'd1);
    e.neg = 1'b0;
`ifdef BCD_SINAL_EN
    if (v[w-1]) begin
      mag   = (64'd1 << w) - mag;
      e.neg = 1'b1;
    end
`endif
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    e.ovf = (mag >= lim);
    t     = mag % lim;
    e.dig = '0;
    for (int i = 0; i < d; i++) begin
      e.dig[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    e.cyc = pcyc;
    return e;
  endfunction

  task automatic applyStimulus(input int dut, input logic [31:0] v, input logic [1:0] ctl, input bit push);
    int k;
    k = cyc + 1;
    case (dut)
      0: begin
        bus32.binario = v; bus32.controlesaida = ctl; bus32.inicio = 1'b1;
        if (push) q32.push_back(mkExp(v, 32, 10, k + 33));
      end
      1: begin
        bus16.binario = v[15:0]; bus16.controlesaida = ctl; bus16.inicio = 1'b1;
        if (push) q16.push_back(mkExp(v, 16, 3, k + 17));
      end
      default: begin
        bus8.binario = v[7:0]; bus8.controlesaida = ctl; bus8.inicio = 1'b1;
        if (push) q8.push_back(mkExp(v, 8, 3, k + 9));
      end
    endcase
    @(negedge clock);
    bus32.inicio = 1'b0; bus16.inicio = 1'b0; bus8.inicio = 1'b0;
    bus32.controlesaida = 2'b00; bus16.controlesaida = 2'b00; bus8.controlesaida = 2'b00;
  endtask

  task automatic waitIdle(input int dut);
    int n;
    n = 0;
    while (n < 200 && ((dut == 0) ? q32.size() : (dut == 1) ? q16.size() : q8.size()) != 0) begin
      @(negedge clock);
      n++;
    end
    checkOutput($sformatf("drain%0d", dut),
                64'((dut == 0) ? q32.size() : (dut == 1) ? q16.size() : q8.size()), 64'd0);
  endtask

  // Each pronto pulse must match the oldest outstanding expectation, including its cycle.
  always @(negedge clock) begin
    if (bus32.pronto) begin
      if (q32.size() == 0) checkOutput("spurious32", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q32.pop_front();
        checkOutput("dig32", 64'(bus32.digitos), e.dig);
        checkOutput("ovf32", 64'(bus32.overflow), 64'(e.ovf));
        checkOutput("neg32", 64'(bus32.negativo), 64'(e.neg));
        checkOutput("lat32", 64'(cyc), 64'(e.cyc));
      end
    end
    if (bus16.pronto) begin
      if (q16.size() == 0) checkOutput("spurious16", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q16.pop_front();
        checkOutput("dig16", 64'(bus16.digitos), e.dig);
        checkOutput("ovf16", 64'(bus16.overflow), 64'(e.ovf));
        checkOutput("lat16", 64'(cyc), 64'(e.cyc));
      end
    end
    if (bus8.pronto) begin
      if (q8.size() == 0) checkOutput("spurious8", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        checkOutput("dig8", 64'(bus8.digitos), e.dig);
        checkOutput("ovf8", 64'(bus8.overflow), 64'(e.ovf));
        checkOutput("neg8", 64'(bus8.negativo), 64'(e.neg));
        checkOutput("lat8", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    int n;
    logic [31:0] r;
    bus32.inicio = 1'b0; bus32.controlesaida = 2'b00; bus32.binario = '0;
    bus16.inicio = 1'b0; bus16.controlesaida = 2'b00; bus16.binario = '0;
    bus8.inicio  = 1'b0; bus8.controlesaida  = 2'b00; bus8.binario  = '0;
    repeat (3) @(negedge clock);
    checkOutput("rstBusy", 64'(bus32.ocupado), 64'd0);
    checkOutput("rstPronto", 64'(bus32.pronto), 64'd0);
    checkOutput("rstDig32", 64'(bus32.digitos), 64'd0);
    checkOutput("rstOvf", 64'(bus32.overflow), 64'd0);
    checkOutput("rstNeg", 64'(bus32.negativo), 64'd0);
    checkOutput("rstDig16", 64'(bus16.digitos), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    // 255: busy for exactly WIDTH cycles, result after WIDTH+1
    applyStimulus(0, 32'd255, 2'b01, 1'b1);
    n = 0;
    while (bus32.ocupado && n < 100) begin
      n++;
      @(negedge clock);
    end
    checkOutput("busy32", 64'(n), 64'd32);
    waitIdle(0);

    // max value, then a start during FIM
    applyStimulus(0, 32'hFFFF_FFFF, 2'b01, 1'b1);
    repeat (32) @(negedge clock);
    applyStimulus(0, 32'd0, 2'b01, 1'b1);
    checkOutput("b2bBusy", 64'(bus32.ocupado), 64'd1);
    waitIdle(0);

    // re-pulsed start mid-conversion must be ignored
    applyStimulus(0, 32'd12345678, 2'b01, 1'b1);
    repeat (5) @(negedge clock);
    applyStimulus(0, 32'd777, 2'b01, 1'b0);
    waitIdle(0);
    repeat (40) @(negedge clock);

    // wrong output-select code: nothing starts, result held
    applyStimulus(0, 32'd42, 2'b10, 1'b0);
    checkOutput("selBusy", 64'(bus32.ocupado), 64'd0);
    checkOutput("selHold", 64'(bus32.digitos), mkExp(32'd12345678, 32, 10, 0).dig);
    repeat (40) @(negedge clock);

    // reset in the middle of a conversion discards it
    applyStimulus(0, 32'd987654, 2'b01, 1'b0);
    repeat (9) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("midRstBusy", 64'(bus32.ocupado), 64'd0);
    checkOutput("midRstDig", 64'(bus32.digitos), 64'd0);
    checkOutput("midRstPronto", 64'(bus32.pronto), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    applyStimulus(0, 32'd4321, 2'b01, 1'b1);
    waitIdle(0);

    // 16-bit / 3-digit instance around the overflow boundary
    applyStimulus(1, 32'd1000, 2'b01, 1'b1);
    waitIdle(1);
    applyStimulus(1, 32'd999, 2'b01, 1'b1);
    waitIdle(1);
    applyStimulus(1, 32'd65535, 2'b01, 1'b1);
    waitIdle(1);
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      applyStimulus(1, r, 2'b01, 1'b1);
      waitIdle(1);
    end

    // 8-bit / 3-digit instance: sign handling depends on the build
    applyStimulus(2, 32'h85, 2'b01, 1'b1);
    waitIdle(2);
    applyStimulus(2, 32'h80, 2'b01, 1'b1);
    waitIdle(2);
    applyStimulus(2, 32'h07, 2'b01, 1'b1);
    waitIdle(2);
    applyStimulus(2, 32'hFF, 2'b01, 1'b1);
    waitIdle(2);

    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      applyStimulus(0, r, 2'b01, 1'b1);
      waitIdle(0);
    end

    repeat (40) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiscompares);
    $finish;
  end

endmodule
